// File: rtl/bi_shift_ctrl.sv
// Command sequencer for a bidirectional WIDTH-bit shift register: runs LOAD,
// ROTATE or CLEAR as a burst of shift-enable cycles and collects the shifted-out bits.
module bi_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH+1)+1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             dir_in,
  input  logic [CW-1:0]    nshift,
  input  logic [WIDTH-1:0] tx_data,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] rx_data,
  output logic             sr_en,
  output logic             sr_sin,
  output logic             sr_dir,
  input  logic             sr_sout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [1:0]    MODE_LOAD   = 2'b00;
  localparam logic [1:0]    MODE_ROTATE = 2'b01;
  localparam logic [1:0]    MODE_ILL    = 2'b11;
  localparam logic [CW-1:0] N_FULL      = CW'(WIDTH);

  state_t           state_reg;
  logic [1:0]       mode_reg;
  logic             dir_reg;
  logic [WIDTH-1:0] tx_reg;
  logic [CW-1:0]    n_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] rx_reg;
  logic             done_reg;
  logic             err_reg;

  logic [CW-1:0]    n_next;
  logic [WIDTH-1:0] tx_rev;
  logic [WIDTH-1:0] cnt_sel;
  logic             load_bit;
  logic             sr_sin_next;

  // Shift count for the incoming command; ROTATE is clamped to one full turn.
  always_comb begin
    n_next = N_FULL;
    if (mode == MODE_ROTATE)
      n_next = (nshift > N_FULL) ? N_FULL : nshift;
  end

  // Right shifts feed tx LSB first, left shifts MSB first: a one-hot of the
  // step counter picks the bit from tx or its bit-reversed copy.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitsel
      assign tx_rev[gi]  = tx_reg[WIDTH-1-gi];
      assign cnt_sel[gi] = (cnt_reg == CW'(gi));
    end
  endgenerate

  assign load_bit = |(cnt_sel & (dir_reg ? tx_reg : tx_rev));

  always_comb begin
    sr_sin_next = 1'b0;
    if (state_reg == ST_SHIFT) begin
      case (mode_reg)
        MODE_LOAD:   sr_sin_next = load_bit;
        MODE_ROTATE: sr_sin_next = sr_sout;
        default:     sr_sin_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      mode_reg  <= MODE_LOAD;
      dir_reg   <= 1'b0;
      tx_reg    <= '0;
      n_reg     <= '0;
      cnt_reg   <= '0;
      rx_reg    <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (mode == MODE_ILL) begin
              err_reg <= 1'b1;
            end else begin
              mode_reg <= mode;
              dir_reg  <= dir_in;
              tx_reg   <= tx_data;
              n_reg    <= n_next;
              cnt_reg  <= '0;
              rx_reg   <= '0;
              if (n_next != '0) begin
                state_reg <= ST_SHIFT;
              end else begin
                state_reg <= ST_DONE;
                done_reg  <= 1'b1;
              end
            end
          end
        end
        ST_SHIFT: begin
          // Collect the bit leaving the register at the same edge it shifts.
          if (dir_reg)
            rx_reg <= {sr_sout, rx_reg[WIDTH-1:1]};
          else
            rx_reg <= {rx_reg[WIDTH-2:0], sr_sout};
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == n_reg - CW'(1)) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready   = (state_reg == ST_IDLE);
  assign busy    = (state_reg == ST_SHIFT) || (state_reg == ST_DONE);
  assign done    = done_reg;
  assign err     = err_reg;
  assign rx_data = rx_reg;
  assign sr_en   = (state_reg == ST_SHIFT);
  assign sr_sin  = sr_sin_next;
  assign sr_dir  = dir_reg;

endmodule

// File: doc/bi_shift_ctrl.md
Name: bi_shift_ctrl

Overview:
Sequencing controller for the bidirectional WIDTH-bit shift register. It accepts one command at a time: parallel load, rotate or clear. It then drives the register's serial input, direction and shift-enable for the required number of cycles and captures the bits shifted out into a parallel word. A single-cycle done pulse closes each command. It sits between the control logic and the shift-register datapath.

Parameters:
WIDTH, 4, bit width of the controlled shift register and of tx_data/rx_data
CW, $clog2(WIDTH+1)+1, width of nshift (must hold values above WIDTH so clamping is exercisable)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (reset==0 resets on next clk edge)
start  input  1  command request, sampled only when ready==1
mode  input  2  00 LOAD, 01 ROTATE, 10 CLEAR, 11 illegal
dir_in  input  1  1 = shift right (Sin->Q[WIDTH-1], Sout=Q[0]); 0 = shift left (Sin->Q[0], Sout=Q[WIDTH-1])
nshift  input  CW  shift count for ROTATE; ignored by LOAD/CLEAR
tx_data  input  WIDTH  word to load (LOAD only)
ready  output  1  high only in IDLE
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse at command completion
err  output  1  one-cycle pulse on illegal command
rx_data  output  WIDTH  bits shifted out by last command, valid when done==1, held until next accept
sr_en  output  1  shift enable to register; register shifts on edge where sr_en==1
sr_sin  output  1  serial data to register
sr_dir  output  1  direction to register
sr_sout  input  1  serial output of register (combinational from Q)

Behaviour:
- Reset (reset==0 at edge): state=IDLE, done=0, err=0, sr_en=0, sr_sin=0, sr_dir=0, rx_data=0, counter=0. ready=1, busy=0 from first cycle after reset.
- States: IDLE, SHIFT, DONE.
- IDLE and start==1, mode!=11: accept at edge. Latch mode, dir_in, tx_data, and n: n=WIDTH for LOAD/CLEAR; n=min(nshift,WIDTH) for ROTATE. Clear rx_data and counter. Next state SHIFT if n>0, else DONE.
- IDLE and start==1, mode==11: err=1 for exactly the next cycle. Stay IDLE; no latching. rx_data unchanged.
- start while busy: ignored, no error.
- SHIFT: sr_en=1 and sr_dir=latched dir, both combinational from registered state. counter k runs 0..n-1.
  - sr_sin in LOAD with dir=1: tx[k] (LSB first).
  - sr_sin in LOAD with dir=0: tx[WIDTH-1-k] (MSB first).
  - sr_sin in ROTATE: sr_sout (combinational feedback).
  - sr_sin in CLEAR: 0.
- Each SHIFT edge captures sr_sout into rx_data.
  - dir=1: rx shifts right, new bit into rx[WIDTH-1].
  - dir=0: rx shifts left, new bit into rx[0].
  - After n=WIDTH shifts, rx_data equals the register's pre-command contents. For n<WIDTH, only the n edge positions are filled; the remainder is 0.
  - k increments. At k==n-1 the next state is DONE.
- DONE: exactly one cycle with done=1, sr_en=0, sr_sin=0. Next state IDLE.
- Latency: accept edge E0; shifts on edges E1..En; done high in cycle after En. Occupancy is n+1 cycles after accept; next command can be accepted in the first IDLE cycle.
- Outside SHIFT: sr_en=0, sr_sin=0, and sr_dir holds the last latched dir.
- Reset mid-command: abort at the reset edge. No done pulse. rx_data=0. Register contents are the partially shifted value; no recovery is attempted.

Test Plan:
1. WIDTH=4, bench shifter model =0000; LOAD tx=1011 dir=1 -> sr_sin 1,1,0,1 on 4 consecutive sr_en cycles; done on 5th cycle after accept; Q=1011; rx_data=0000.
2. Then LOAD tx=0110 dir=0 -> sr_sin 0,1,1,0; Q=0110; rx_data=1011.
3. Q=1011, ROTATE dir=1 nshift=1 -> one sr_en cycle; Q=1101; rx_data=1000; done 2 cycles after accept.
4. ROTATE nshift=0 -> sr_en never high, done the cycle after accept. ROTATE nshift=7 -> clamped to 4, Q unchanged, rx_data=Q.
5. mode=11 with start -> err pulse 1 cycle, ready stays 1, rx_data unchanged. start pulsed during SHIFT -> ignored, no extra done.
6. reset=0 after 2 shifts of a LOAD -> next cycle sr_en=0, ready=1, rx_data=0, no done. Then CLEAR -> Q=0000, rx_data equals the prior Q.
